// File: rtl/intersection_traffic_model_pkg.sv
// Shared types, default parameters and the per-lane colour transition rule for the
// intersection traffic model (vehicles side of the sensor/light interface).
package intersection_traffic_model_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } color_e;

    // Lane identities. On the packed vectors (arrive/depart) the bit index is 2 - lane.
    typedef enum logic [1:0] {
        EW_LEFT = 2'd0,
        EW_STR  = 2'd1,
        NS      = 2'd2
    } lane_e;

    localparam int          N_LANES        = 3;
    localparam int          QMAX_DEF       = 15;
    localparam int          DEPART_GAP_DEF = 2;
    localparam int          MAX_WAIT_DEF   = 64;
    localparam logic [1:0]  LIGHT_ILLEGAL  = 2'b11;

    // A lane may hold its colour or advance red->green->yellow->red.
    function automatic logic legal_transition(color_e prev, color_e cur);
        logic ok;
        ok = (prev == cur);
        case (prev)
            RED:     ok = ok | (cur == GREEN);
            GREEN:   ok = ok | (cur == YELLOW);
            YELLOW:  ok = ok | (cur == RED);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/intersection_traffic_model_if.sv
// Sensor/light bundle between the traffic light controller and the vehicle model.
// The master modport is the vehicle model; the slave modport is the controller side.
// Optional SERVED_COUNT_EN adds the per-lane served counters.
interface intersection_traffic_model_if #(
    parameter int QW = $clog2(intersection_traffic_model_pkg::QMAX_DEF + 1)
);
    logic [2:0]    arrive;
    logic [1:0]    ew_left_light;
    logic [1:0]    ew_str_light;
    logic [1:0]    ns_light;
    logic          ew_left_sensor;
    logic          ew_str_sensor;
    logic          ns_sensor;
    logic [2:0]    depart;
    logic [QW-1:0] ew_left_q;
    logic [QW-1:0] ew_str_q;
    logic [QW-1:0] ns_q;
    logic          err_conflict;
    logic          err_encoding;
    logic          err_sequence;
    logic          err_overflow;
    logic          err_starve;
`ifdef SERVED_COUNT_EN
    logic [15:0]   ew_left_served;
    logic [15:0]   ew_str_served;
    logic [15:0]   ns_served;
`endif

    modport master (
        input  arrive, ew_left_light, ew_str_light, ns_light,
        output ew_left_sensor, ew_str_sensor, ns_sensor, depart,
        output ew_left_q, ew_str_q, ns_q,
        output err_conflict, err_encoding, err_sequence, err_overflow, err_starve
`ifdef SERVED_COUNT_EN
        , output ew_left_served, ew_str_served, ns_served
`endif
    );

    modport slave (
        output arrive, ew_left_light, ew_str_light, ns_light,
        input  ew_left_sensor, ew_str_sensor, ns_sensor, depart,
        input  ew_left_q, ew_str_q, ns_q,
        input  err_conflict, err_encoding, err_sequence, err_overflow, err_starve
`ifdef SERVED_COUNT_EN
        , input ew_left_served, ew_str_served, ns_served
`endif
    );

endinterface

// File: rtl/intersection_traffic_model_lane_queue.sv
// One lane of vehicles: saturating queue, departure spacing timer, red-light wait
// counter with starvation flag, and per-lane colour sequence check.
// Optional SERVED_COUNT_EN adds a wrapping 16-bit departure counter.
module intersection_traffic_model_lane_queue
    import intersection_traffic_model_pkg::*;
#(
    parameter int QMAX       = QMAX_DEF,
    parameter int DEPART_GAP = DEPART_GAP_DEF,
    parameter int MAX_WAIT   = MAX_WAIT_DEF,
    parameter int QW         = $clog2(QMAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive_i,
    input  logic [1:0]    light_i,
    output logic          depart_o,
    output logic [QW-1:0] q_o,
    output logic          sensor_o,
    output logic          err_sequence_o,
    output logic          err_overflow_o,
    output logic          err_starve_o
`ifdef SERVED_COUNT_EN
    , output logic [15:0] served_o
`endif
);

    // Timer only needs to hold DEPART_GAP-1; keep at least one bit for DEPART_GAP==1.
    localparam int TW = (DEPART_GAP > 1) ? $clog2(DEPART_GAP) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    localparam logic [QW-1:0] Q_FULL     = QW'(QMAX);
    localparam logic [TW-1:0] GAP_RELOAD = TW'(DEPART_GAP - 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    logic [QW-1:0] q_q, q_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [WW-1:0] wait_q, wait_d;
    color_e        prev_q, prev_d;
    logic          depart_q, depart_d;
    logic          err_seq_q, err_seq_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_starve_q, err_starve_d;
    logic          go;

    // Next-state for queue, timer, wait counter, colour history and sticky errors.
    always_comb begin
        go           = (light_i == GREEN) && (q_q != '0) && (timer_q == '0);
        depart_d     = go;
        q_d          = q_q;
        timer_d      = '0;
        wait_d       = '0;
        prev_d       = prev_q;
        err_seq_d    = err_seq_q;
        err_ovf_d    = err_ovf_q;
        err_starve_d = err_starve_q;

        // Arrival and departure in the same cycle cancel out.
        if (arrive_i && !go) begin
            if (q_q == Q_FULL) begin
                err_ovf_d = 1'b1;
            end else begin
                q_d = q_q + 1'b1;
            end
        end else if (go && !arrive_i) begin
            q_d = q_q - 1'b1;
        end

        // Spacing timer only runs on green, so the first green edge can depart at once.
        if (light_i == GREEN) begin
            if (go) begin
                timer_d = GAP_RELOAD;
            end else if (timer_q != '0) begin
                timer_d = timer_q - 1'b1;
            end
        end

        // Occupied lane held at red: count, saturate, flag when the limit is reached.
        if ((light_i == RED) && (q_q != '0)) begin
            wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + 1'b1;
            if (wait_d == WAIT_LIMIT) begin
                err_starve_d = 1'b1;
            end
        end

        // An illegal encoding is left to the encoding check and does not disturb history.
        if (light_i != LIGHT_ILLEGAL) begin
            prev_d = color_e'(light_i);
            if (!legal_transition(prev_q, color_e'(light_i))) begin
                err_seq_d = 1'b1;
            end
        end
    end

    // Lane state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q          <= '0;
            timer_q      <= '0;
            wait_q       <= '0;
            prev_q       <= RED;
            depart_q     <= 1'b0;
            err_seq_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_starve_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            timer_q      <= timer_d;
            wait_q       <= wait_d;
            prev_q       <= prev_d;
            depart_q     <= depart_d;
            err_seq_q    <= err_seq_d;
            err_ovf_q    <= err_ovf_d;
            err_starve_q <= err_starve_d;
        end
    end

`ifdef SERVED_COUNT_EN
    logic [15:0] served_q;

    // Departure tally, wrapping naturally at 2^16.
    always_ff @(posedge clk) begin
        if (reset) begin
            served_q <= '0;
        end else begin
            served_q <= served_q + {15'd0, go};
        end
    end

    assign served_o = served_q;
`endif

    assign depart_o       = depart_q;
    assign q_o            = q_q;
    assign sensor_o       = (q_q != '0);
    assign err_sequence_o = err_seq_q;
    assign err_overflow_o = err_ovf_q;
    assign err_starve_o   = err_starve_q;

endmodule

// File: rtl/intersection_traffic_model.sv
// Closed-loop vehicle model for the intersection: three lane queues driven by the
// controller's lights, plus cross-lane conflict and encoding checks.
// Optional SERVED_COUNT_EN exposes per-lane served counters.
module intersection_traffic_model
    import intersection_traffic_model_pkg::*;
#(
    parameter int QMAX       = QMAX_DEF,
    parameter int DEPART_GAP = DEPART_GAP_DEF,
    parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
    input logic                          clk,
    input logic                          reset,
    intersection_traffic_model_if.master bus
);

    localparam int QW = $clog2(QMAX + 1);

    // Index 2 = ew_left, 1 = ew_str, 0 = ns, matching arrive/depart bit order.
    logic [N_LANES-1:0][1:0] lights;
    logic [N_LANES-1:0]      depart_w, sensor_w, seq_w, ovf_w, starve_w;
    logic [QW-1:0]           q_w [N_LANES];
`ifdef SERVED_COUNT_EN
    logic [15:0]             served_w [N_LANES];
`endif

    assign lights = {bus.ew_left_light, bus.ew_str_light, bus.ns_light};

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            intersection_traffic_model_lane_queue #(
                .QMAX       (QMAX),
                .DEPART_GAP (DEPART_GAP),
                .MAX_WAIT   (MAX_WAIT),
                .QW         (QW)
            ) u_lane (
                .clk            (clk),
                .reset          (reset),
                .arrive_i       (bus.arrive[gi]),
                .light_i        (lights[gi]),
                .depart_o       (depart_w[gi]),
                .q_o            (q_w[gi]),
                .sensor_o       (sensor_w[gi]),
                .err_sequence_o (seq_w[gi]),
                .err_overflow_o (ovf_w[gi]),
                .err_starve_o   (starve_w[gi])
`ifdef SERVED_COUNT_EN
                , .served_o     (served_w[gi])
`endif
            );
        end
    endgenerate

    logic [1:0] nonred_cnt;
    logic       any_illegal;
    logic       err_conflict_q, err_conflict_d;
    logic       err_encoding_q, err_encoding_d;

    // Count lanes showing anything other than red and spot the unused encoding.
    always_comb begin
        nonred_cnt  = '0;
        any_illegal = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            nonred_cnt  = nonred_cnt + {1'b0, (lights[i] != RED)};
            any_illegal = any_illegal | (lights[i] == LIGHT_ILLEGAL);
        end
        err_conflict_d = err_conflict_q | (nonred_cnt > 2'd1);
        err_encoding_d = err_encoding_q | any_illegal;
    end

    // Sticky cross-lane error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_conflict_q <= 1'b0;
            err_encoding_q <= 1'b0;
        end else begin
            err_conflict_q <= err_conflict_d;
            err_encoding_q <= err_encoding_d;
        end
    end

    assign bus.ew_left_sensor = sensor_w[2];
    assign bus.ew_str_sensor  = sensor_w[1];
    assign bus.ns_sensor      = sensor_w[0];
    assign bus.depart         = depart_w;
    assign bus.ew_left_q      = q_w[2];
    assign bus.ew_str_q       = q_w[1];
    assign bus.ns_q           = q_w[0];
    assign bus.err_conflict   = err_conflict_q;
    assign bus.err_encoding   = err_encoding_q;
    assign bus.err_sequence   = |seq_w;
    assign bus.err_overflow   = |ovf_w;
    assign bus.err_starve     = |starve_w;
`ifdef SERVED_COUNT_EN
    assign bus.ew_left_served = served_w[2];
    assign bus.ew_str_served  = served_w[1];
    assign bus.ns_served      = served_w[0];
`endif

endmodule

// File: tb/tb_intersection_traffic_model.sv
// Self-checking bench for intersection_traffic_model: directed vector table, hand
// sequences for overflow/conflict/sequence/encoding/starvation, then random traffic
// against a lane-level reference model. Honours SERVED_COUNT_EN when defined.
module tb_intersection_traffic_model;

    localparam int QMAX = 15;
    localparam int GAP  = 2;
    localparam int MAXW = 64;
    localparam logic [1:0] R = 2'd0, Y = 2'd1, G = 2'd2, X = 2'd3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    intersection_traffic_model_if bus ();
    intersection_traffic_model dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model, lane index = vector bit (2 ew_left, 1 ew_str, 0 ns).
    int m_q[3], m_t[3], m_w[3], m_prev[3], m_served[3];
    bit m_dep[3];
    bit e_conf, e_enc, e_seq, e_ovf, e_starve;
    int nxt_col[3] = '{2, 0, 1};  // colour that may follow red, yellow, green

    task automatic model_reset();
        for (int l = 0; l < 3; l++) begin
            m_q[l] = 0; m_t[l] = 0; m_w[l] = 0; m_prev[l] = 0; m_served[l] = 0; m_dep[l] = 0;
        end
        e_conf = 0; e_enc = 0; e_seq = 0; e_ovf = 0; e_starve = 0;
    endtask

    task automatic model_edge(input logic rst, input logic [2:0] arr,
                              input logic [1:0] lel, les, lns);
        int lt[3];
        int nonred;
        bit dep;
        if (rst) begin
            model_reset();
            return;
        end
        lt[2] = int'(lel); lt[1] = int'(les); lt[0] = int'(lns);
        nonred = 0;
        for (int l = 0; l < 3; l++) begin
            if (lt[l] != 0) nonred++;
            if (lt[l] == 3) e_enc = 1;
            else begin
                if (lt[l] != m_prev[l] && lt[l] != nxt_col[m_prev[l]]) e_seq = 1;
                m_prev[l] = lt[l];
            end
            dep = (lt[l] == 2) && (m_q[l] > 0) && (m_t[l] == 0);
            if (lt[l] == 0 && m_q[l] > 0) begin
                m_w[l] = (m_w[l] + 1 > MAXW) ? MAXW : m_w[l] + 1;
                if (m_w[l] == MAXW) e_starve = 1;
            end else m_w[l] = 0;
            if (lt[l] != 2) m_t[l] = 0;
            else if (dep) m_t[l] = GAP - 1;
            else if (m_t[l] > 0) m_t[l] = m_t[l] - 1;
            if (arr[l] && !dep) begin
                if (m_q[l] == QMAX) e_ovf = 1;
                else m_q[l]++;
            end else if (dep && !arr[l]) m_q[l]--;
            m_dep[l] = dep;
            if (dep) m_served[l] = (m_served[l] + 1) % 65536;
        end
        if (nonred > 1) e_conf = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [4:0] dut_errs();
        return {bus.err_conflict, bus.err_encoding, bus.err_sequence, bus.err_overflow, bus.err_starve};
    endfunction

    task automatic compare_model();
        chk("model_depart", 32'(bus.depart), 32'({m_dep[2], m_dep[1], m_dep[0]}));
        chk("model_q_ew_left", 32'(bus.ew_left_q), 32'(m_q[2]));
        chk("model_q_ew_str", 32'(bus.ew_str_q), 32'(m_q[1]));
        chk("model_q_ns", 32'(bus.ns_q), 32'(m_q[0]));
        chk("model_sensors", 32'({bus.ew_left_sensor, bus.ew_str_sensor, bus.ns_sensor}),
            32'({m_q[2] != 0, m_q[1] != 0, m_q[0] != 0}));
        chk("model_errors", 32'(dut_errs()), 32'({e_conf, e_enc, e_seq, e_ovf, e_starve}));
`ifdef SERVED_COUNT_EN
        chk("model_served_ew_left", 32'(bus.ew_left_served), 32'(m_served[2]));
        chk("model_served_ew_str", 32'(bus.ew_str_served), 32'(m_served[1]));
        chk("model_served_ns", 32'(bus.ns_served), 32'(m_served[0]));
`endif
    endtask

    // One clock of stimulus, model update and comparison; prints one line.
    task automatic step(input logic rst, input logic [2:0] arr,
                        input logic [1:0] lel, les, lns);
        reset = rst; bus.arrive = arr;
        bus.ew_left_light = lel; bus.ew_str_light = les; bus.ns_light = lns;
        @(posedge clk);
        model_edge(rst, arr, lel, les, lns);
        #1;
        cyc++;
        $display("cyc %0d rst=%b arr=%b lights=%0d/%0d/%0d dep=%b q=%0d/%0d/%0d err=%b",
                 cyc, rst, arr, lel, les, lns, bus.depart,
                 bus.ew_left_q, bus.ew_str_q, bus.ns_q, dut_errs());
        compare_model();
    endtask

    typedef struct {
        logic [2:0] arr;
        logic [1:0] lel, les, lns;
        logic [2:0] dep;
        logic [3:0] qel, qes, qns;
        logic [2:0] sens;
        logic [4:0] err;
    } vec_t;

    vec_t vecs[15];
    logic [1:0] cur[3];

    initial begin
        // Tests 1-3: queue up ew_left, serve it on green, then ns arrival-with-departure.
        vecs[0]  = '{3'b100, R, R, R, 3'b000, 4'd1, 4'd0, 4'd0, 3'b100, 5'b0};
        vecs[1]  = '{3'b100, R, R, R, 3'b000, 4'd2, 4'd0, 4'd0, 3'b100, 5'b0};
        vecs[2]  = '{3'b100, R, R, R, 3'b000, 4'd3, 4'd0, 4'd0, 3'b100, 5'b0};
        vecs[3]  = '{3'b000, G, R, R, 3'b100, 4'd2, 4'd0, 4'd0, 3'b100, 5'b0};
        vecs[4]  = '{3'b000, G, R, R, 3'b000, 4'd2, 4'd0, 4'd0, 3'b100, 5'b0};
        vecs[5]  = '{3'b000, G, R, R, 3'b100, 4'd1, 4'd0, 4'd0, 3'b100, 5'b0};
        vecs[6]  = '{3'b000, G, R, R, 3'b000, 4'd1, 4'd0, 4'd0, 3'b100, 5'b0};
        vecs[7]  = '{3'b000, G, R, R, 3'b100, 4'd0, 4'd0, 4'd0, 3'b000, 5'b0};
        vecs[8]  = '{3'b000, G, R, R, 3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 5'b0};
        vecs[9]  = '{3'b000, Y, R, R, 3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 5'b0};
        vecs[10] = '{3'b000, R, R, R, 3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 5'b0};
        vecs[11] = '{3'b001, R, R, R, 3'b000, 4'd0, 4'd0, 4'd1, 3'b001, 5'b0};
        vecs[12] = '{3'b001, R, R, G, 3'b001, 4'd0, 4'd0, 4'd1, 3'b001, 5'b0};
        vecs[13] = '{3'b000, R, R, Y, 3'b000, 4'd0, 4'd0, 4'd1, 3'b001, 5'b0};
        vecs[14] = '{3'b000, R, R, R, 3'b000, 4'd0, 4'd0, 4'd1, 3'b001, 5'b0};

        model_reset();
        step(1'b1, 3'b000, R, R, R);
        step(1'b1, 3'b000, R, R, R);
        chk("reset_q_all", 32'({bus.ew_left_q, bus.ew_str_q, bus.ns_q}), 32'd0);
        chk("reset_depart_sensors", 32'({bus.depart, bus.ew_left_sensor, bus.ew_str_sensor, bus.ns_sensor}), 32'd0);
        chk("reset_errors", 32'(dut_errs()), 32'd0);

        for (int i = 0; i < 15; i++) begin
            step(1'b0, vecs[i].arr, vecs[i].lel, vecs[i].les, vecs[i].lns);
            chk($sformatf("vec%0d_depart", i), 32'(bus.depart), 32'(vecs[i].dep));
            chk($sformatf("vec%0d_q_ew_left", i), 32'(bus.ew_left_q), 32'(vecs[i].qel));
            chk($sformatf("vec%0d_q_ew_str", i), 32'(bus.ew_str_q), 32'(vecs[i].qes));
            chk($sformatf("vec%0d_q_ns", i), 32'(bus.ns_q), 32'(vecs[i].qns));
            chk($sformatf("vec%0d_sensors", i),
                32'({bus.ew_left_sensor, bus.ew_str_sensor, bus.ns_sensor}), 32'(vecs[i].sens));
            chk($sformatf("vec%0d_errors", i), 32'(dut_errs()), 32'(vecs[i].err));
`ifdef SERVED_COUNT_EN
            if (i == 10) chk("served_ew_left_after_green", 32'(bus.ew_left_served), 32'd3);
`endif
        end

        // Test 4: 17 ew_str arrivals at red; saturation and overflow on arrival 16.
        step(1'b1, 3'b000, R, R, R);
        for (int k = 1; k <= 17; k++) begin
            step(1'b0, 3'b010, R, R, R);
            if (k == 15) chk("ovf_q_at_15", 32'(bus.ew_str_q), 32'd15);
            if (k == 15) chk("ovf_flag_at_15", 32'(bus.err_overflow), 32'd0);
            if (k == 16) chk("ovf_flag_at_16", 32'(bus.err_overflow), 32'd1);
            if (k == 17) chk("ovf_q_held", 32'(bus.ew_str_q), 32'd15);
        end

        // Test 5: conflict, encoding without history update, then green->red.
        step(1'b1, 3'b000, R, R, R);
        step(1'b0, 3'b000, R, G, R);
        step(1'b0, 3'b000, R, Y, G);
        chk("conflict_set", 32'(bus.err_conflict), 32'd1);
        chk("conflict_no_seq", 32'(bus.err_sequence), 32'd0);
        step(1'b0, 3'b000, R, R, Y);
        step(1'b0, 3'b000, R, R, R);
        step(1'b0, 3'b000, R, R, X);
        step(1'b0, 3'b000, R, R, G);
        chk("encoding_set", 32'(bus.err_encoding), 32'd1);
        chk("encoding_keeps_history", 32'(bus.err_sequence), 32'd0);
        step(1'b0, 3'b000, R, R, Y);
        step(1'b0, 3'b000, R, R, R);
        step(1'b0, 3'b000, G, R, R);
        step(1'b0, 3'b000, R, R, R);
        chk("sequence_set", 32'(bus.err_sequence), 32'd1);
        for (int k = 0; k < 5; k++) step(1'b0, 3'b000, R, R, R);
        chk("errors_sticky", 32'({bus.err_conflict, bus.err_encoding, bus.err_sequence}), 32'b111);
        step(1'b1, 3'b000, R, R, R);
        chk("errors_cleared", 32'(dut_errs()), 32'd0);

        // Test 6: one ns vehicle held at red; starvation at the 64th wait edge.
        step(1'b0, 3'b001, R, R, R);
        for (int k = 1; k <= MAXW; k++) begin
            step(1'b0, 3'b000, R, R, R);
            if (k == MAXW - 1) chk("starve_not_at_63", 32'(bus.err_starve), 32'd0);
            if (k == MAXW) chk("starve_at_64", 32'(bus.err_starve), 32'd1);
        end

        // Random traffic, mostly legal light progressions, occasional faults and resets.
        step(1'b1, 3'b000, R, R, R);
        cur[0] = R; cur[1] = R; cur[2] = R;
        for (int n = 0; n < 1500; n++) begin
            logic [2:0] arr;
            int ln;
            logic rst;
            for (int l = 0; l < 3; l++) arr[l] = ($urandom_range(0, 3) == 0);
            ln = $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0) begin
                case (cur[ln])
                    R:       cur[ln] = G;
                    G:       cur[ln] = Y;
                    default: cur[ln] = R;
                endcase
            end else if ($urandom_range(0, 59) == 0) begin
                cur[ln] = 2'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 299) == 0);
            step(rst, arr, cur[2], cur[1], cur[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
